// File: rtl/charmatrix_pkg.sv
// Shared types and constants for the character-matrix serial front-end.
// Holds frame-format enums, receiver FSM states and oversampling constants.
package charmatrix_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_e;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned SAMPLE_MID = 8;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; push into a full FIFO is
// accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        head    = mem_q[rd_ptr_q];
        count   = count_q;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled UART receiver with configurable data bits and parity,
// sticky error flags and a show-ahead FIFO with valid/ready output.
module uart_rx_fifo
    import charmatrix_pkg::parity_e, charmatrix_pkg::PAR_NONE, charmatrix_pkg::PAR_ODD,
           charmatrix_pkg::rx_state_e, charmatrix_pkg::IDLE, charmatrix_pkg::START,
           charmatrix_pkg::DATA, charmatrix_pkg::STOP, charmatrix_pkg::BREAK,
           charmatrix_pkg::OVERSAMPLE, charmatrix_pkg::SAMPLE_MID, charmatrix_pkg::majority3;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            ena,
    input  logic                            rx,
    output logic [DATA_BITS-1:0]            rx_data,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            frame_err,
    output logic                            parity_err,
    output logic                            overrun,
    input  logic                            err_clr
);

    localparam int unsigned DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int unsigned DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BCW = $clog2(DATA_BITS);
    localparam int unsigned SW  = $clog2(OVERSAMPLE);
    localparam logic [SW:0] S_MID  = (SW+1)'(SAMPLE_MID);
    localparam logic [SW:0] S_VOTE = (SW+1)'(SAMPLE_MID + 1);
    localparam logic [SW:0] S_END  = (SW+1)'(OVERSAMPLE);
    localparam parity_e PAR_MODE = parity_e'(PARITY[1:0]);

    if (DIV < 2) begin : g_div_chk
        $error("uart_rx_fifo: baud divider must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_chk
        $error("uart_rx_fifo: DATA_BITS must be 5..8");
    end
    if (PARITY > 2) begin : g_par_chk
        $error("uart_rx_fifo: PARITY must be 0, 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e            state_q;
    logic [DCW-1:0]       div_q;
    logic [SW-1:0]        samp_q;
    logic [SW:0]          samp_idx;
    logic [BCW-1:0]       bit_cnt_q;
    logic [1:0]           votes_q;
    logic [DATA_BITS-1:0] shreg_q, push_data_q;
    logic                 par_bad_q, push_q;
    logic                 frame_err_q, parity_err_q, overrun_q;
    logic                 tick, bit_val, exp_par, stop_decide;
    logic                 fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;

    // samp_idx is the 1-based index of the current tick within the bit.
    always_comb begin
        tick        = (state_q != IDLE) && (div_q == DCW'(DIV - 1));
        samp_idx    = (SW+1)'(samp_q) + (SW+1)'(1);
        bit_val     = majority3({votes_q, rx_sync_q});
        exp_par     = (^shreg_q) ^ (PAR_MODE == PAR_ODD);
        stop_decide = ena && (state_q == STOP) && tick && (samp_idx == S_MID);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            samp_q    <= '0;
            bit_cnt_q <= '0;
            votes_q   <= '1;
            shreg_q   <= '0;
            par_bad_q <= 1'b0;
        end else if (!ena) begin
            state_q <= IDLE;
            div_q   <= '0;
            samp_q  <= '0;
        end else begin
            if (tick) begin
                div_q   <= '0;
                samp_q  <= samp_idx[SW-1:0];
                votes_q <= {votes_q[0], rx_sync_q};
            end else if (state_q != IDLE) begin
                div_q <= div_q + DCW'(1);
            end else begin
                div_q <= '0;
            end
            unique case (state_q)
                IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q   <= START;
                        div_q     <= '0;
                        samp_q    <= '0;
                        bit_cnt_q <= '0;
                        par_bad_q <= 1'b0;
                    end
                end
                START: begin
                    if (tick && samp_idx == S_MID && rx_sync_q) begin
                        state_q <= IDLE;
                    end else if (tick && samp_idx == S_END) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (tick && samp_idx == S_VOTE) begin
                        shreg_q <= {bit_val, shreg_q[DATA_BITS-1:1]};
                    end
                    if (tick && samp_idx == S_END) begin
                        bit_cnt_q <= bit_cnt_q + BCW'(1);
                        if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                            state_q <= (PAR_MODE != PAR_NONE) ? charmatrix_pkg::PARITY : STOP;
                        end
                    end
                end
                charmatrix_pkg::PARITY: begin
                    if (tick && samp_idx == S_VOTE) par_bad_q <= (bit_val != exp_par);
                    if (tick && samp_idx == S_END)  state_q <= STOP;
                end
                STOP: begin
                    // Leave at mid stop bit so the next start edge is never missed.
                    if (tick && samp_idx == S_MID) state_q <= bit_val ? IDLE : BREAK;
                end
                BREAK: begin
                    if (rx_sync_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_q       <= 1'b0;
            push_data_q  <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            push_q <= stop_decide && bit_val && !par_bad_q;
            if (stop_decide) push_data_q <= shreg_q;
            if (err_clr) begin
                frame_err_q  <= 1'b0;
                parity_err_q <= 1'b0;
                overrun_q    <= 1'b0;
            end
            if (stop_decide && !bit_val)            frame_err_q  <= 1'b1;
            if (stop_decide && par_bad_q)           parity_err_q <= 1'b1;
            if (push_q && fifo_full && !rx_ready)   overrun_q    <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_q),
        .push_data(push_data_q),
        .pop      (rx_ready),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        rx_valid   = ~fifo_empty;
        rx_data    = rx_valid ? fifo_head : '0;
        frame_err  = frame_err_q;
        parity_err = parity_err_q;
        overrun    = overrun_q;
    end

endmodule
